// File: rtl/ysyx_23060203_mem_arbiter.sv
// Core-side AXI arbiter: serialises ICache burst refills and LSU single-beat
// reads/writes onto one master port, with one transaction in flight at a time.
module ysyx_23060203_mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  // ICache refill read
  input  logic        ifu_ar_valid,
  input  logic [31:0] ifu_ar_addr,
  input  logic [7:0]  ifu_ar_len,
  input  logic [2:0]  ifu_ar_size,
  output logic        ifu_ar_ready,
  output logic        ifu_r_valid,
  output logic [31:0] ifu_r_data,
  output logic [1:0]  ifu_r_resp,
  output logic        ifu_r_last,
  input  logic        ifu_r_ready,
  // LSU read
  input  logic        lsu_ar_valid,
  input  logic [31:0] lsu_ar_addr,
  input  logic [2:0]  lsu_ar_size,
  output logic        lsu_ar_ready,
  output logic        lsu_r_valid,
  output logic [31:0] lsu_r_data,
  output logic [1:0]  lsu_r_resp,
  input  logic        lsu_r_ready,
  // LSU write
  input  logic        lsu_aw_valid,
  input  logic [31:0] lsu_aw_addr,
  input  logic [2:0]  lsu_aw_size,
  input  logic        lsu_w_valid,
  input  logic [31:0] lsu_w_data,
  input  logic [3:0]  lsu_w_strb,
  output logic        lsu_aw_ready,
  output logic        lsu_w_ready,
  output logic        lsu_b_valid,
  output logic [1:0]  lsu_b_resp,
  input  logic        lsu_b_ready,
  // Slave side
  output logic        mem_ar_valid,
  output logic [31:0] mem_ar_addr,
  output logic [7:0]  mem_ar_len,
  output logic [2:0]  mem_ar_size,
  output logic [1:0]  mem_ar_burst,
  input  logic        mem_ar_ready,
  input  logic        mem_r_valid,
  input  logic [31:0] mem_r_data,
  input  logic [1:0]  mem_r_resp,
  input  logic        mem_r_last,
  output logic        mem_r_ready,
  output logic        mem_aw_valid,
  output logic [31:0] mem_aw_addr,
  output logic [2:0]  mem_aw_size,
  output logic        mem_w_valid,
  output logic [31:0] mem_w_data,
  output logic [3:0]  mem_w_strb,
  output logic        mem_w_last,
  input  logic        mem_aw_ready,
  input  logic        mem_w_ready,
  input  logic        mem_b_valid,
  input  logic [1:0]  mem_b_resp,
  output logic        mem_b_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP
  } state_e;

  state_e      state_q, state_d;
  logic        owner_ifu_q, owner_ifu_d;
  logic        last_ifu_q, last_ifu_d;
  logic        rd_seen_q, rd_seen_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic        pick_ifu;

  // Round-robin tie-break: IFU wins a tie only when the previous read went to
  // the LSU; before any read has completed the LSU wins.
  always_comb begin
    pick_ifu = ifu_ar_valid && (!lsu_ar_valid || (rd_seen_q && !last_ifu_q));
  end

  // Next-state, request latching and grant readies
  always_comb begin
    state_d      = state_q;
    owner_ifu_d  = owner_ifu_q;
    last_ifu_d   = last_ifu_q;
    rd_seen_d    = rd_seen_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    ifu_ar_ready = 1'b0;
    lsu_ar_ready = 1'b0;
    lsu_aw_ready = 1'b0;
    lsu_w_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!reset) begin
          if (lsu_aw_valid && lsu_w_valid) begin
            lsu_aw_ready = 1'b1;
            lsu_w_ready  = 1'b1;
            addr_d       = lsu_aw_addr;
            size_d       = lsu_aw_size;
            wdata_d      = lsu_w_data;
            wstrb_d      = lsu_w_strb;
            aw_pend_d    = 1'b1;
            w_pend_d     = 1'b1;
            state_d      = S_WREQ;
          end else if (ifu_ar_valid || lsu_ar_valid) begin
            owner_ifu_d = pick_ifu;
            state_d     = S_RADDR;
            if (pick_ifu) begin
              ifu_ar_ready = 1'b1;
              addr_d       = ifu_ar_addr;
              len_d        = ifu_ar_len;
              size_d       = ifu_ar_size;
            end else begin
              lsu_ar_ready = 1'b1;
              addr_d       = lsu_ar_addr;
              len_d        = '0;
              size_d       = lsu_ar_size;
            end
          end
        end
      end
      S_RADDR: begin
        if (mem_ar_ready) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (mem_r_valid && mem_r_ready && mem_r_last) begin
          state_d    = S_IDLE;
          last_ifu_d = owner_ifu_q;
          rd_seen_d  = 1'b1;
        end
      end
      S_WREQ: begin
        // Address and data channels retire independently, in either order.
        aw_pend_d = aw_pend_q && !mem_aw_ready;
        w_pend_d  = w_pend_q && !mem_w_ready;
        if (!aw_pend_d && !w_pend_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (mem_b_valid && lsu_b_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_ifu_q <= 1'b0;
      last_ifu_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_ifu_q <= owner_ifu_d;
      last_ifu_q  <= last_ifu_d;
      rd_seen_q   <= rd_seen_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
    end
  end

  // Slave request channels driven from latched fields
  always_comb begin
    mem_ar_valid = (state_q == S_RADDR);
    mem_ar_addr  = addr_q;
    mem_ar_len   = len_q;
    mem_ar_size  = size_q;
    mem_ar_burst = 2'b01;
    mem_aw_valid = (state_q == S_WREQ) && aw_pend_q;
    mem_aw_addr  = addr_q;
    mem_aw_size  = size_q;
    mem_w_valid  = (state_q == S_WREQ) && w_pend_q;
    mem_w_data   = wdata_q;
    mem_w_strb   = wstrb_q;
    mem_w_last   = 1'b1;
  end

  // Response routing: slave beats pass straight through to the owner
  always_comb begin
    ifu_r_valid = (state_q == S_RDATA) && owner_ifu_q && mem_r_valid;
    ifu_r_data  = mem_r_data;
    ifu_r_resp  = mem_r_resp;
    ifu_r_last  = mem_r_last;
    lsu_r_valid = (state_q == S_RDATA) && !owner_ifu_q && mem_r_valid;
    lsu_r_data  = mem_r_data;
    lsu_r_resp  = mem_r_resp;
    mem_r_ready = (state_q == S_RDATA) && (owner_ifu_q ? ifu_r_ready : lsu_r_ready);
    lsu_b_valid = (state_q == S_WRESP) && mem_b_valid;
    lsu_b_resp  = mem_b_resp;
    mem_b_ready = (state_q == S_WRESP) && lsu_b_ready;
  end

endmodule
